dmem_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds on the CPU core's data-memory bus (address/wdata/wen/ren/size in, registered rdata out). It sits next to the data RAM in the SoC, decodes its own address window, buffers store-issued bytes in a small FIFO, and serializes them as 8N1 frames on a single TX pin. The block gives running programs a console output path without changing the CPU core.

---
 rtl/dmem_uart_tx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dmem_uart_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
//
// Stores to TXDATA queue a byte in a small FIFO. A serializer drains the FIFO
// and sends each byte as start bit, 8 data bits (LSB first) and stop bit.
// Back-to-back bytes go out with no idle gap between frames.
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 TXDATA  write: push wdata[7:0]                    read: 0
//   0x4 STATUS  write: wdata[3]=1 clears overflow          read: {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}
//   0x8, 0xC    reserved, read 0, writes ignored
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous active-high reset
//   dmem_addr_i   byte address
//   dmem_wdata_i  store data
//   dmem_wen_i    store strobe (one cycle per store)
//   dmem_ren_i    load strobe (one cycle per load)
//   dmem_size_i   access size (any size is accepted)
//   dmem_rdata_o  registered load data, holds while dmem_ren_i is low
//   uart_tx_o     serial output, idle high, driven from a flop
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic        dmem_wen_i,
  input  logic        dmem_ren_i,
  input  logic [1:0]  dmem_size_i,
  output logic [31:0] dmem_rdata_o,
  output logic        uart_tx_o
);

  localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(32'd1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(32'd1);
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Bus decode
  logic        hit_s;
  logic [1:0]  reg_sel_s;
  logic        aligned_s;
  logic        push_req_s;
  logic        ovf_clr_s;
  logic        unused_bits_s;

  // FIFO
  logic [7:0]  fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0] count_r;
  logic        overflow_r;
  logic        full_s;
  logic        empty_s;
  logic        push_ok_s;
  logic        ovf_set_s;
  logic [7:0]  fifo_head_s;
  logic [8:0]  count_ext_s;

  // Serializer
  state_t      state_r;
  state_t      state_n;
  logic        tx_r;
  logic        tx_n;
  logic [7:0]  shift_r;
  logic [7:0]  shift_n;
  logic [2:0]  bit_cnt_r;
  logic [2:0]  bit_cnt_n;
  logic [15:0] baud_cnt_r;
  logic [15:0] baud_cnt_n;
  logic        pop_s;
  logic        busy_s;

  // Read path
  logic [31:0] status_s;
  logic [31:0] rd_sel_s;
  logic [31:0] rdata_r;

  assign hit_s      = (dmem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel_s  = dmem_addr_i[3:2];
  assign aligned_s  = (dmem_addr_i[1:0] == 2'b00);
  assign push_req_s = hit_s & dmem_wen_i & aligned_s & (reg_sel_s == 2'd0);
  assign ovf_clr_s  = hit_s & dmem_wen_i & aligned_s & (reg_sel_s == 2'd1) & dmem_wdata_i[3];
  // Store size and upper store bytes carry no meaning for this block.
  assign unused_bits_s = ^{dmem_size_i, dmem_wdata_i[31:8]};

  assign full_s      = (count_r == DEPTH_C);
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  // A push into a full FIFO still lands when the serializer pops in the same cycle.
  assign push_ok_s   = push_req_s & (~full_s | pop_s);
  assign ovf_set_s   = push_req_s & full_s & ~pop_s;
  assign fifo_head_s = fifo_mem_r[rd_ptr_r];
  assign count_ext_s = 9'(count_r);

  assign busy_s   = (state_r != ST_IDLE);
  assign status_s = {16'h0000, count_ext_s[7:0], 4'h0, overflow_r, busy_s, empty_s, full_s};

  assign uart_tx_o    = tx_r;
  assign dmem_rdata_o = rdata_r;

  // Read-data mux: only STATUS returns non-zero content.
  always_comb begin
    rd_sel_s = 32'h0000_0000;
    if (hit_s) begin
      case (reg_sel_s)
        2'd1:    rd_sel_s = status_s;
        default: rd_sel_s = 32'h0000_0000;
      endcase
    end else begin
      rd_sel_s = 32'h0000_0000;
    end
  end

  // Registered load data; holds when no load is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (dmem_ren_i) begin
      rdata_r <= rd_sel_s;
    end
  end

  // FIFO storage array (contents need no reset, pointers gate validity).
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= dmem_wdata_i[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // Setting has priority over a same-cycle software clear.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Serializer state register and datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_r       <= 1'b1;
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      baud_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_n;
      tx_r       <= tx_n;
      shift_r    <= shift_n;
      bit_cnt_r  <= bit_cnt_n;
      baud_cnt_r <= baud_cnt_n;
    end
  end

  // Serializer next-state, next-output and FIFO pop request.
  always_comb begin
    state_n    = state_r;
    tx_n       = tx_r;
    shift_n    = shift_r;
    bit_cnt_n  = bit_cnt_r;
    baud_cnt_n = baud_cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_cnt_n = 16'd0;
        bit_cnt_n  = 3'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = fifo_head_s;
          tx_n    = 1'b0;
          state_n = ST_START;
        end else begin
          tx_n = 1'b1;
        end
      end
      ST_START: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_n = 16'd0;
          bit_cnt_n  = 3'd0;
          tx_n       = shift_r[0];
          state_n    = ST_DATA;
        end else begin
          baud_cnt_n = baud_cnt_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_n = 16'd0;
          if (bit_cnt_r == 3'd7) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            // Bit 0 of the shifter is always the bit currently on the line.
            bit_cnt_n = bit_cnt_r + 3'd1;
            shift_n   = {1'b0, shift_r[7:1]};
            tx_n      = shift_r[1];
          end
        end else begin
          baud_cnt_n = baud_cnt_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_n = 16'd0;
          bit_cnt_n  = 3'd0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_n = fifo_head_s;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt_r + 16'd1;
        end
      end
      default: begin
        tx_n       = 1'b1;
        baud_cnt_n = 16'd0;
        bit_cnt_n  = 3'd0;
        state_n    = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Directed bench for dmem_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Every clock tick compares uart_tx_o with a queue of hand-built frame bits
// (idle high when the queue is empty); bus reads compare against constants.
module tb_dmem_uart_tx;

  logic        clock;
  logic        reset;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_wen_i;
  logic        dmem_ren_i;
  logic [1:0]  dmem_size_i;
  logic [31:0] dmem_rdata_o;
  logic        uart_tx_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e1     = 0;
  logic exp_q[$];

  dmem_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_wen_i   (dmem_wen_i),
    .dmem_ren_i   (dmem_ren_i),
    .dmem_size_i  (dmem_size_i),
    .dmem_rdata_o (dmem_rdata_o),
    .uart_tx_o    (uart_tx_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check the TX line.
  task automatic tick();
    logic e;
    @(posedge clock);
    #1;
    cyc++;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 1'b1;
    checks++;
    assert (uart_tx_o === e) else begin
      errors++;
      $error("FAIL tx_line cyc=%0d observed=%b expected=%b", cyc, uart_tx_o, e);
    end
  endtask

  // Expected 8N1 waveform of one byte, 4 cycles per bit.
  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      logic bv;
      bv = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
      repeat (4) exp_q.push_back(bv);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    dmem_addr_i  = addr;
    dmem_wdata_i = data;
    dmem_wen_i   = 1'b1;
    tick();
    dmem_wen_i   = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr);
    dmem_addr_i = addr;
    dmem_ren_i  = 1'b1;
    tick();
    dmem_ren_i  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    dmem_addr_i  = 32'h0;
    dmem_wdata_i = 32'h0;
    dmem_wen_i   = 1'b0;
    dmem_ren_i   = 1'b0;
    dmem_size_i  = 2'b00;

    // Reset and idle
    tick();
    tick();
    chk("reset_rdata", dmem_rdata_o, 32'h0);
    reset = 1'b0;
    repeat (100) tick();
    load(32'h0000_1004);
    chk("idle_status", dmem_rdata_o, 32'h0000_0002);
    tick();
    chk("rdata_hold", dmem_rdata_o, 32'h0000_0002);

    // Single frame 0xA5
    store(32'h0000_1000, 32'h0000_00A5);
    push_frame(8'hA5);
    repeat (45) tick();

    // Three back-to-back frames, status polled throughout
    dmem_size_i = 2'b10;
    store(32'h0000_1000, 32'hFFFF_FF41);
    push_frame(8'h41);
    store(32'h0000_1000, 32'h0000_0042);
    e1 = cyc;
    push_frame(8'h42);
    push_frame(8'h43);
    store(32'h0000_1000, 32'h0000_0043);
    dmem_size_i = 2'b00;
    dmem_addr_i = 32'h0000_1004;
    dmem_ren_i  = 1'b1;
    while (cyc < e1 + 120) begin
      tick();
      chk("busy_run", {31'h0, dmem_rdata_o[2]}, 32'd1);
      chk("empty_run", {31'h0, dmem_rdata_o[1]}, (cyc >= e1 + 81) ? 32'd1 : 32'd0);
    end
    tick();
    chk("busy_done", {31'h0, dmem_rdata_o[2]}, 32'd0);
    dmem_ren_i = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (10) tick();

    // Fill FIFO, overflow, clear
    store(32'h0000_1000, 32'h0000_0011);
    push_frame(8'h11);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h20 + 8'(i);
      store(32'h0000_1000, {24'h0, v});
      push_frame(v);
    end
    store(32'h0000_1000, 32'h0000_00EE);
    load(32'h0000_1004);
    chk("status_full_ovf", dmem_rdata_o, 32'h0000_080D);
    store(32'h0000_1004, 32'h0000_0008);
    load(32'h0000_1004);
    chk("status_ovf_clr", dmem_rdata_o, 32'h0000_0805);
    while (exp_q.size() > 0) tick();
    repeat (20) tick();
    load(32'h0000_1004);
    chk("status_after_fill", dmem_rdata_o, 32'h0000_0002);

    // Misses, misaligned store, reserved registers
    load(32'h0000_0100);
    chk("miss_read", dmem_rdata_o, 32'h0);
    store(32'h0000_1001, 32'h0000_0077);
    repeat (5) tick();
    load(32'h0000_1004);
    chk("misaligned_no_push", dmem_rdata_o, 32'h0000_0002);
    load(32'h0000_1008);
    chk("reserved_read", dmem_rdata_o, 32'h0);
    load(32'h0000_1004);
    chk("status_pre_reset", dmem_rdata_o, 32'h0000_0002);
    load(32'h0000_1000);
    chk("txdata_read", dmem_rdata_o, 32'h0);
    load(32'h0000_1004);
    repeat (20) tick();

    // Reset in the middle of DATA
    store(32'h0000_1000, 32'h0000_005A);
    push_frame(8'h5A);
    store(32'h0000_1000, 32'h0000_003C);
    repeat (18) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("midreset_rdata", dmem_rdata_o, 32'h0);
    load(32'h0000_1004);
    chk("midreset_status", dmem_rdata_o, 32'h0000_0002);
    repeat (10) tick();
    store(32'h0000_1000, 32'h0000_00C3);
    push_frame(8'hC3);
    while (exp_q.size() > 0) tick();
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
